fifo_flagged: RTL and testbench

//   Parametrised synchronous FIFO, next generation of the team's basic FIFO.

---
 rtl/fifo_flagged.sv | 129 ++++++++++++
 tb/tb_fifo_flagged.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_flagged.sv
// Synchronous FIFO with any-depth pointer wrap, fill level, programmable almost flags,
// sticky overflow/underflow errors and selectable standard or first-word-fall-through read.
module fifo_flagged #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0,
  localparam int LW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [LW-1:0]         level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_accept;
  logic          rd_accept;

  assign full         = (level_q == LW'(FIFO_DEPTH));
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LW'(AFULL_THRESH));
  assign almost_empty = (level_q <= LW'(AEMPTY_THRESH));
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Acceptance uses the pre-edge flags, so a read cannot make room for a write in the same cycle.
  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;

    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A set request in the same cycle as clr_err leaves the flag set.
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
    if (rd_en && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : mem[rd_ptr_q];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = dout_q;
        if (rd_accept) begin
          dout_d = mem[rd_ptr_q];
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          dout_q <= '0;
        end else begin
          dout_q <= dout_d;
        end
      end

      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_flagged.sv
// Directed bench for fifo_flagged: table-driven vectors on a 16-deep standard FIFO plus
// hand sequences for depth-5 wrap, FWFT read mode and asynchronous mid-stream reset.
module tb_fifo_flagged;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] m_dout, d_dout, f_dout;
  logic [4:0] m_lvl, f_lvl;
  logic [2:0] d_lvl;
  logic m_full, m_empty, m_af, m_ae, m_ovf, m_unf;
  logic d_full, d_empty, d_af, d_ae, d_ovf, d_unf;
  logic f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  fifo_flagged #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AFULL_THRESH(12), .AEMPTY_THRESH(2), .FWFT(0)) u_main (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(m_dout), .full(m_full), .empty(m_empty), .almost_full(m_af),
    .almost_empty(m_ae), .level(m_lvl), .overflow(m_ovf), .underflow(m_unf), .clr_err(clr_err)
  );

  fifo_flagged #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .AFULL_THRESH(4), .AEMPTY_THRESH(1), .FWFT(0)) u_d5 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(d_dout), .full(d_full), .empty(d_empty), .almost_full(d_af),
    .almost_empty(d_ae), .level(d_lvl), .overflow(d_ovf), .underflow(d_unf), .clr_err(clr_err)
  );

  fifo_flagged #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AFULL_THRESH(12), .AEMPTY_THRESH(2), .FWFT(1)) u_fw (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .level(f_lvl), .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
  );

  typedef struct {
    logic       wr, rd, clr;
    logic [7:0] din;
    logic [7:0] dout;
    logic [4:0] lvl;
    logic       ovf, unf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic wr, input logic rd, input logic clr, input logic [7:0] din,
                              input logic [7:0] dout, input int lvl, input logic ovf, input logic unf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
    v.dout = dout; v.lvl = 5'(lvl); v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic clr, input logic [7:0] din);
    wr_en = wr; rd_en = rd; clr_err = clr; data_in = din;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    // Test 1: fill to full, then an overflowing write.
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    for (int i = 0; i < 16; i++) tbl.push_back(mk(1, 0, 0, 8'(i), 8'h00, i + 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'hAA, 8'h00, 16, 1, 0));
    // Test 2: drain, one underflowing read, then clear errors.
    for (int i = 0; i < 16; i++) tbl.push_back(mk(0, 1, 0, 8'h00, 8'(i), 15 - i, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 8'h0F, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 8'h00, 8'h0F, 0, 0, 0));
    // Test 3: steady state at level 8, then simultaneous access at full and at empty.
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 0, 8'(8'h20 + i), 8'h0F, i + 1, 0, 0));
    for (int k = 0; k < 10; k++) tbl.push_back(mk(1, 1, 0, 8'(8'h28 + k), 8'(8'h20 + k), 8, 0, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 0, 8'(8'h32 + i), 8'h29, 9 + i, 0, 0));
    tbl.push_back(mk(1, 1, 0, 8'hEE, 8'h2A, 15, 1, 0));
    for (int i = 0; i < 15; i++) tbl.push_back(mk(0, 1, 0, 8'h00, 8'(8'h2B + i), 14 - i, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 8'h39, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 8'h77, 8'h39, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 8'h77, 0, 0, 1));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      drive(v.wr, v.rd, v.clr, v.din);
      n_vec++;
      chk("data_out",     i, 32'(m_dout),  32'(v.dout));
      chk("level",        i, 32'(m_lvl),   32'(v.lvl));
      chk("full",         i, 32'(m_full),  32'(v.lvl == 5'd16));
      chk("empty",        i, 32'(m_empty), 32'(v.lvl == 5'd0));
      chk("almost_full",  i, 32'(m_af),    32'(v.lvl >= 5'd12));
      chk("almost_empty", i, 32'(m_ae),    32'(v.lvl <= 5'd2));
      chk("overflow",     i, 32'(m_ovf),   32'(v.ovf));
      chk("underflow",    i, 32'(m_unf),   32'(v.unf));
      $display("vec %0d: wr=%0d rd=%0d clr=%0d din=%02h -> dout=%02h lvl=%0d ovf=%0d unf=%0d",
               i, v.wr, v.rd, v.clr, v.din, m_dout, m_lvl, m_ovf, m_unf);
    end

    // Test 4: depth-5 FIFO, pointers wrap 4->0 several times.
    do_reset();
    for (int rep = 0; rep < 4; rep++) begin
      for (int j = 0; j < 3; j++) begin
        drive(1, 0, 0, 8'(8'h40 + rep * 3 + j));
        n_vec++;
        chk("d5_level_wr", n_vec, 32'(d_lvl), 32'(j + 1));
        chk("d5_afull",    n_vec, 32'(d_af),  32'(0));
      end
      for (int j = 0; j < 3; j++) begin
        drive(0, 1, 0, 8'h00);
        n_vec++;
        chk("d5_dout",     n_vec, 32'(d_dout), 32'(8'h40 + rep * 3 + j));
        chk("d5_level_rd", n_vec, 32'(d_lvl),  32'(2 - j));
        chk("d5_aempty",   n_vec, 32'(d_ae),   32'(j >= 1));
      end
      $display("d5 round %0d: last dout=%02h lvl=%0d", rep, d_dout, d_lvl);
    end
    n_vec++;
    chk("d5_overflow",  n_vec, 32'(d_ovf), 32'(0));
    chk("d5_underflow", n_vec, 32'(d_unf), 32'(0));

    // Test 5: FWFT head visibility and pop.
    do_reset();
    n_vec++;
    chk("fw_reset_dout", n_vec, 32'(f_dout), 32'(0));
    drive(1, 0, 0, 8'h5A);
    n_vec++;
    chk("fw_head",  n_vec, 32'(f_dout),  32'(8'h5A));
    chk("fw_empty", n_vec, 32'(f_empty), 32'(0));
    $display("fwft write 5A: dout=%02h empty=%0d", f_dout, f_empty);
    drive(0, 1, 0, 8'h00);
    n_vec++;
    chk("fw_pop_empty", n_vec, 32'(f_empty), 32'(1));
    chk("fw_pop_dout",  n_vec, 32'(f_dout),  32'(0));
    drive(1, 0, 0, 8'h11);
    drive(1, 0, 0, 8'h22);
    drive(0, 1, 0, 8'h00);
    n_vec++;
    chk("fw_second_head", n_vec, 32'(f_dout), 32'(8'h22));
    chk("fw_level",       n_vec, 32'(f_lvl),  32'(1));
    $display("fwft after pop of 11: dout=%02h lvl=%0d", f_dout, f_lvl);

    // Test 6: asynchronous reset mid-stream at level 7 with overflow set.
    do_reset();
    for (int i = 0; i < 16; i++) drive(1, 0, 0, 8'(8'h80 + i));
    drive(1, 0, 0, 8'hFF);
    for (int i = 0; i < 9; i++) drive(0, 1, 0, 8'h00);
    n_vec++;
    chk("pre_rst_level", n_vec, 32'(m_lvl),  32'(7));
    chk("pre_rst_ovf",   n_vec, 32'(m_ovf),  32'(1));
    chk("pre_rst_dout",  n_vec, 32'(m_dout), 32'(8'h88));
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    chk("rst_level", n_vec, 32'(m_lvl),   32'(0));
    chk("rst_empty", n_vec, 32'(m_empty), 32'(1));
    chk("rst_ovf",   n_vec, 32'(m_ovf),   32'(0));
    chk("rst_dout",  n_vec, 32'(m_dout),  32'(0));
    $display("async reset: lvl=%0d empty=%0d ovf=%0d dout=%02h", m_lvl, m_empty, m_ovf, m_dout);
    #2 reset_n = 1'b1;
    drive(0, 1, 1, 8'h00);
    n_vec++;
    chk("clr_rd_unf",   n_vec, 32'(m_unf), 32'(1));
    chk("clr_rd_level", n_vec, 32'(m_lvl), 32'(0));
    $display("clr_err+rd on empty: unf=%0d lvl=%0d", m_unf, m_lvl);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
